// File: rtl/data_memory_pipelined_pkg.sv
// Shared encodings and helpers for the pipelined byte-addressed data memory
// and the load alignment logic it shares with the cache.
package data_memory_pipelined_pkg;

   localparam int unsigned WORD_W = 32;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   // Load payload captured at accept and carried down the read pipeline
   typedef struct packed {
      logic [WORD_W-1:0] word;
      logic [1:0]        lane;
      logic [1:0]        size;
      logic              uns;
      logic              write;
      logic              err;
   } ld_stage_t;

   function automatic int unsigned clog2_u(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/data_memory_pipelined_load_align_extend.sv
// Lane select plus sign/zero extension of a loaded word; purely combinational.
module load_align_extend
   import data_memory_pipelined_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic [DATA_W-1:0] word,
   input  logic [1:0]        lane,
   input  logic [1:0]        size,
   input  logic              uns,
   output logic [DATA_W-1:0] rdata_c
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   assign byte_v = word[{lane, 3'b000} +: 8];
   assign half_v = lane[1] ? word[31:16] : word[15:0];

   always_comb begin
      rdata_c = '0;
      case (size)
         SZ_BYTE: rdata_c = {{(DATA_W-8){~uns & byte_v[7]}}, byte_v};
         SZ_HALF: rdata_c = {{(DATA_W-16){~uns & half_v[15]}}, half_v};
         default: rdata_c = word;
      endcase
   end

endmodule

// File: rtl/data_memory_pipelined.sv
// Byte-addressed data memory with self-clear after reset, byte/half/word
// access, error flagging and a 1- or 2-cycle pipelined read path.
module data_memory_pipelined
   import data_memory_pipelined_pkg::*;
#(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned DEPTH    = 128,
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned READ_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              init_done
);

   localparam int unsigned        IDX_W      = clog2_u(DEPTH);
   localparam logic [ADDR_W:0]    ADDR_LIMIT = (ADDR_W+1)'(DEPTH * 4);

   state_t            state, state_nx;
   logic [IDX_W-1:0]  ptr, ptr_nx;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              accept_c;
   logic              err_c;
   logic              store_c;
   logic [IDX_W-1:0]  idx_c;
   logic [3:0]        be_c;
   logic [DATA_W-1:0] wdata_c;
   ld_stage_t         acc_c;

   logic              fin_valid;
   ld_stage_t         fin;
   logic [DATA_W-1:0] ext_c;

   // Clear/run controller state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_CLEAR;
         ptr       <= '0;
         req_ready <= 1'b0;
         init_done <= 1'b0;
      end else begin
         state     <= state_nx;
         ptr       <= ptr_nx;
         req_ready <= (state_nx == ST_RUN);
         init_done <= (state_nx == ST_RUN);
      end
   end

   always_comb begin
      state_nx = state;
      ptr_nx   = ptr;
      case (state)
         ST_CLEAR: begin
            ptr_nx = ptr + IDX_W'(1);
            if (ptr == IDX_W'(DEPTH - 1)) state_nx = ST_RUN;
         end
         ST_RUN: state_nx = ST_RUN;
      endcase
   end

   assign accept_c = req_valid & req_ready;
   assign idx_c    = req_addr[IDX_W+1:2];

   // Alignment, size and range checks
   always_comb begin
      err_c = 1'b0;
      case (req_size)
         SZ_BYTE: err_c = 1'b0;
         SZ_HALF: err_c = req_addr[0];
         SZ_WORD: err_c = |req_addr[1:0];
         default: err_c = 1'b1;
      endcase
      if ({1'b0, req_addr} >= ADDR_LIMIT) err_c = 1'b1;
   end

   // Byte enables and lane-replicated store data
   always_comb begin
      be_c    = 4'b0000;
      wdata_c = req_wdata;
      case (req_size)
         SZ_BYTE: begin
            be_c    = 4'b0001 << req_addr[1:0];
            wdata_c = {4{req_wdata[7:0]}};
         end
         SZ_HALF: begin
            be_c    = req_addr[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{req_wdata[15:0]}};
         end
         SZ_WORD: be_c = 4'b1111;
         default: be_c = 4'b0000;
      endcase
   end

   assign store_c = accept_c & req_write & ~err_c;

   // Storage array: cleared word-by-word in CLEAR, byte-masked stores in RUN
   always_ff @(posedge clk) begin
      if (state == ST_CLEAR) begin
         mem[ptr] <= '0;
      end else if (store_c) begin
         for (int i = 0; i < 4; i++) begin
            if (be_c[i]) mem[idx_c][8*i +: 8] <= wdata_c[8*i +: 8];
         end
      end
   end

   always_comb begin
      acc_c       = '0;
      acc_c.word  = mem[idx_c];
      acc_c.lane  = req_addr[1:0];
      acc_c.size  = req_size;
      acc_c.uns   = req_unsigned;
      acc_c.write = req_write;
      acc_c.err   = err_c;
   end

   generate
      if (READ_LAT == 2) begin : g_lat2
         logic      s1_valid;
         ld_stage_t s1;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s1_valid <= 1'b0;
               s1       <= '0;
            end else begin
               s1_valid <= accept_c;
               s1       <= acc_c;
            end
         end

         assign fin_valid = s1_valid;
         assign fin       = s1;
      end else begin : g_lat1
         assign fin_valid = accept_c;
         assign fin       = acc_c;
      end
   endgenerate

   load_align_extend #(.DATA_W(DATA_W)) u_align (
      .word    (fin.word),
      .lane    (fin.lane),
      .size    (fin.size),
      .uns     (fin.uns),
      .rdata_c (ext_c)
   );

   // Response register; stores and errors return zero data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= fin_valid;
         rsp_err   <= fin_valid & fin.err;
         rsp_rdata <= (fin_valid & ~fin.err & ~fin.write) ? ext_c : '0;
      end
   end

endmodule

// File: tb/tb_data_memory_pipelined.sv
// Scoreboard bench: READ_LAT=1 and READ_LAT=2 instances share one stimulus
// stream; each has its own expected-response queue with due cycles.
module tb_data_memory_pipelined;
   import data_memory_pipelined_pkg::*;

   localparam int unsigned DEPTH = 128;

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = '0;
   logic [1:0]  req_size = SZ_WORD;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_wdata = '0;

   logic        ready1, rv1, re1, done1;
   logic [31:0] rd1;
   logic        ready2, rv2, re2, done2;
   logic [31:0] rd2;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   exp_t q1[$];
   exp_t q2[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   data_memory_pipelined #(.DEPTH(DEPTH), .READ_LAT(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready1),
      .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
      .req_unsigned(req_unsigned), .req_wdata(req_wdata), .rsp_valid(rv1),
      .rsp_rdata(rd1), .rsp_err(re1), .init_done(done1)
   );

   data_memory_pipelined #(.DEPTH(DEPTH), .READ_LAT(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready2),
      .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
      .req_unsigned(req_unsigned), .req_wdata(req_wdata), .rsp_valid(rv2),
      .rsp_rdata(rd2), .rsp_err(re2), .init_done(done2)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // Response monitors: pop and compare data, error flag and arrival cycle
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && rv1) begin
         if (q1.size() == 0) check_eq("lat1_unexpected_rsp", 32'(rv1), 32'd0);
         else begin
            e = q1.pop_front();
            check_eq("lat1_rdata", rd1, e.data);
            check_eq("lat1_err", 32'(re1), 32'(e.err));
            check_eq("lat1_cycle", 32'(cyc), 32'(e.due));
         end
      end
      if (rst_n && rv2) begin
         if (q2.size() == 0) check_eq("lat2_unexpected_rsp", 32'(rv2), 32'd0);
         else begin
            e = q2.pop_front();
            check_eq("lat2_rdata", rd2, e.data);
            check_eq("lat2_err", 32'(re2), 32'(e.err));
            check_eq("lat2_cycle", 32'(cyc), 32'(e.due));
         end
      end
   end

   // Drive one request for one cycle; called just after a rising edge
   task automatic issue(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata,
                        input logic [31:0] exp_data, input logic exp_err);
      exp_t e;
      req_valid    = 1'b1;
      req_write    = wr;
      req_addr     = addr;
      req_size     = size;
      req_unsigned = uns;
      req_wdata    = wdata;
      e.data = exp_data;
      e.err  = exp_err;
      e.due  = cyc + 1;
      q1.push_back(e);
      e.due  = cyc + 2;
      q2.push_back(e);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic drain();
      repeat (3) @(posedge clk);
      for (int i = 0; i < 20 && (q1.size() != 0 || q2.size() != 0); i++) @(posedge clk);
      #1;
      check_eq("drain_lat1_missing", 32'(q1.size()), 32'd0);
      check_eq("drain_lat2_missing", 32'(q2.size()), 32'd0);
      q1.delete();
      q2.delete();
   endtask

   task automatic release_and_init(input string tag);
      int n;
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!ready1 && n < 1000);
      check_eq({tag, "_clear_cycles"}, 32'(n), 32'(DEPTH));
      check_eq({tag, "_ready2"}, 32'(ready2), 32'd1);
      check_eq({tag, "_init_done1"}, 32'(done1), 32'd1);
      check_eq({tag, "_init_done2"}, 32'(done2), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_req_ready", 32'(ready1), 32'd0);
      check_eq("rst_rsp_valid", 32'(rv1), 32'd0);
      check_eq("rst_rsp_rdata", rd1, 32'd0);
      check_eq("rst_rsp_err", 32'(re1), 32'd0);
      check_eq("rst_init_done", 32'(done1), 32'd0);
      check_eq("rst_rsp_valid2", 32'(rv2), 32'd0);
      release_and_init("init");

      // Cleared memory, top word
      issue(1'b0, 32'h1FC, SZ_WORD, 1'b0, '0, 32'h0000_0000, 1'b0);

      // Word store then sized/extended loads
      issue(1'b1, 32'h10, SZ_WORD, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0);
      issue(1'b0, 32'h10, SZ_WORD, 1'b0, '0, 32'hDEAD_BEEF, 1'b0);
      issue(1'b0, 32'h13, SZ_BYTE, 1'b0, '0, 32'hFFFF_FFDE, 1'b0);
      issue(1'b0, 32'h12, SZ_HALF, 1'b1, '0, 32'h0000_DEAD, 1'b0);
      issue(1'b0, 32'h10, SZ_HALF, 1'b0, '0, 32'hFFFF_BEEF, 1'b0);
      issue(1'b0, 32'h10, SZ_BYTE, 1'b1, '0, 32'h0000_00EF, 1'b0);

      // Byte store preserves neighbours
      issue(1'b1, 32'h11, SZ_BYTE, 1'b0, 32'h1234_56AA, 32'h0, 1'b0);
      issue(1'b0, 32'h10, SZ_WORD, 1'b0, '0, 32'hDEAD_AAEF, 1'b0);
      issue(1'b0, 32'h11, SZ_BYTE, 1'b0, '0, 32'hFFFF_FFAA, 1'b0);
      issue(1'b0, 32'h11, SZ_BYTE, 1'b1, '0, 32'h0000_00AA, 1'b0);
      drain();

      // Error cases must not touch memory
      issue(1'b0, 32'h02, SZ_WORD, 1'b0, '0, 32'h0, 1'b1);
      issue(1'b1, 32'h05, SZ_HALF, 1'b0, 32'h0000_FFFF, 32'h0, 1'b1);
      issue(1'b0, 32'h10, 2'b11, 1'b0, '0, 32'h0, 1'b1);
      issue(1'b1, 32'h10, 2'b11, 1'b0, 32'h1111_1111, 32'h0, 1'b1);
      issue(1'b0, 32'h200, SZ_WORD, 1'b0, '0, 32'h0, 1'b1);
      issue(1'b1, 32'h200, SZ_WORD, 1'b0, 32'h5555_5555, 32'h0, 1'b1);
      issue(1'b0, 32'h10, SZ_WORD, 1'b0, '0, 32'hDEAD_AAEF, 1'b0);
      issue(1'b0, 32'h04, SZ_WORD, 1'b0, '0, 32'h0000_0000, 1'b0);
      issue(1'b0, 32'h00, SZ_WORD, 1'b0, '0, 32'h0000_0000, 1'b0);
      drain();

      // Store at N, load at N+1, plus a half store into the upper lanes
      issue(1'b1, 32'h20, SZ_WORD, 1'b0, 32'h1234_5678, 32'h0, 1'b0);
      issue(1'b0, 32'h20, SZ_WORD, 1'b0, '0, 32'h1234_5678, 1'b0);
      issue(1'b1, 32'h26, SZ_HALF, 1'b0, 32'hFFFF_8001, 32'h0, 1'b0);
      issue(1'b0, 32'h24, SZ_WORD, 1'b0, '0, 32'h8001_0000, 1'b0);
      issue(1'b0, 32'h26, SZ_HALF, 1'b0, '0, 32'hFFFF_8001, 1'b0);

      // Continuous one-per-cycle traffic
      for (int i = 0; i < 8; i++)
         issue(1'b1, 32'h40 + 32'(4 * i), SZ_WORD, 1'b0, 32'hA5A5_0000 + 32'(i * 17), 32'h0, 1'b0);
      for (int i = 0; i < 8; i++)
         issue(1'b0, 32'h40 + 32'(4 * i), SZ_WORD, 1'b0, '0, 32'hA5A5_0000 + 32'(i * 17), 1'b0);
      drain();

      // Reset with loads in flight
      issue(1'b0, 32'h20, SZ_WORD, 1'b0, '0, 32'h1234_5678, 1'b0);
      issue(1'b0, 32'h10, SZ_WORD, 1'b0, '0, 32'hDEAD_AAEF, 1'b0);
      rst_n = 1'b0;
      q1.delete();
      q2.delete();
      #1;
      check_eq("midrst_rsp_valid1", 32'(rv1), 32'd0);
      check_eq("midrst_rsp_valid2", 32'(rv2), 32'd0);
      check_eq("midrst_rsp_rdata1", rd1, 32'd0);
      check_eq("midrst_req_ready", 32'(ready1), 32'd0);
      repeat (2) @(posedge clk);
      release_and_init("reinit");
      issue(1'b0, 32'h20, SZ_WORD, 1'b0, '0, 32'h0000_0000, 1'b0);
      issue(1'b0, 32'h10, SZ_WORD, 1'b0, '0, 32'h0000_0000, 1'b0);
      issue(1'b0, 32'h44, SZ_WORD, 1'b0, '0, 32'h0000_0000, 1'b0);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/data_memory_pipelined.md
Name: data_memory_pipelined

Overview:
- Parametrised, byte-addressed data memory for the single-cycle/pipelined CPU datapath; successor to the word-indexed data memory.
- Supports byte/half/word loads and stores with sign or zero extension, a configurable pipelined read latency, and a valid/ready request channel.
- Clears its own array after reset, and flags misaligned or out-of-range accesses.
- Sits between the EX/MEM stage and the MEM/WB register.

Parameters:
- DATA_W, 32, word width in bits; must be 32.
- DEPTH, 128, number of words; power of two, 2..4096.
- ADDR_W, 32, byte-address width.
- READ_LAT, 1, request-to-response latency in cycles; legal values 1 or 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present this cycle.
- req_ready  output  1  block can accept a request; low only while clearing.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  ADDR_W  byte address.
- req_size  input  2  00 = byte, 01 = half, 10 = word; 11 is illegal.
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
- req_wdata  input  DATA_W  store data, right-aligned (low bytes used for byte/half).
- rsp_valid  output  1  response present.
- rsp_rdata  output  DATA_W  extended load data; 0 for stores and errors.
- rsp_err  output  1  misaligned, out-of-range, or illegal-size request.
- init_done  output  1  clear sequence finished.

Behaviour:
- Reset (rst_n low, async):
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0.
  - All pipeline valid bits cleared; the FSM enters CLEAR with clear pointer 0.
- FSM states: CLEAR and RUN.
  - CLEAR writes 0 to word[ptr] each cycle and increments ptr.
  - When ptr=DEPTH-1 has been written, the next cycle enters RUN.
  - In RUN, init_done=1 and req_ready=1. The clear takes exactly DEPTH cycles after reset release.
  - No other transitions; RUN persists until the next reset.
- Acceptance: a request is accepted when req_valid && req_ready. At most one request per cycle, with no back-pressure in RUN.
- Error checks, evaluated in the accept cycle:
  - size=11 is an error.
  - half with addr[0]=1 is an error.
  - word with addr[1:0]!=0 is an error.
  - addr >= DEPTH*4 is an error.
  - An errored request does not modify memory; it still gets a response with rsp_err=1 and rsp_rdata=0.
- Indexing: word index = addr[log2(DEPTH)+1:2]; byte lane = addr[1:0].
- Stores:
  - The write commits at the accept edge, with per-byte enables from size and lane.
  - Byte: lane = wdata[7:0]. Half: lanes {1,0} or {3,2} = wdata[15:0]. Word: all lanes.
  - Unaffected bytes are preserved.
- Loads:
  - The word is read in the accept cycle and captured, together with lane, size, unsigned, write and err.
  - With READ_LAT=2, one extra register stage follows.
  - Extraction and extension happen in the final stage.
- Responses:
  - Every accepted request yields exactly one rsp_valid pulse exactly READ_LAT cycles after acceptance (the cycle after the accept edge for READ_LAT=1).
  - Responses come in order and are fully pipelined, so back-to-back requests give back-to-back responses.
- Hazards:
  - A store accepted at cycle N is visible to a load accepted at cycle N+1 or later.
  - Same-cycle conflict cannot occur (single port).
- Reset mid-operation: in-flight responses are dropped (rsp_valid=0 immediately) and the clear restarts from word 0.
- Requests arriving while req_ready=0 are ignored and produce no response.

Decomposition:
- Shared package holds:
  - size encodings (SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10);
  - FSM state encoding (ST_CLEAR, ST_RUN);
  - clog2 helper for index width.
- One natural sub-module, load_align_extend: combinational lane select plus sign/zero extension, taking word, lane, size and unsigned and returning DATA_W. It is reused by the future cache block.

Test Plan:
- Reset release → req_ready=0 for exactly DEPTH cycles (128 at default), then init_done=1 and req_ready=1; a word load of addr 0x1FC returns 0x00000000.
- Word store 0xDEADBEEF @0x10, then loads @0x10 → rsp_rdata=0xDEADBEEF. Signed byte @0x13 → 0xFFFFFFDE. Unsigned half @0x12 → 0x0000DEAD. Signed half @0x10 → 0xFFFFBEEF.
- Byte store 0xAA @0x11 over 0xDEADBEEF → word load @0x10 returns 0xDEADAABE... no, returns 0xDEADAAEF (other bytes preserved). Response appears READ_LAT cycles after acceptance for READ_LAT=1 and READ_LAT=2 builds.
- Misaligned word load @0x02, half store @0x05, size=11, and address 0x200 (DEPTH=128) → each returns rsp_err=1 and rsp_rdata=0. A follow-up load confirms memory is unchanged.
- Back-to-back store @0x20=0x12345678 at cycle N and load @0x20 at N+1 → load returns 0x12345678; continuous one-per-cycle traffic gives one response every cycle, in order.
- rst_n asserted while two loads are in flight → rsp_valid drops at once, no stale response after release, clear restarts, and previously written data reads 0.
